// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM state encoding, MEM/WB register layout
// and the doubleword alignment rule.
package mem_stage_pkg;

  localparam int MEM_DATA_W = 64;
  localparam int MEM_ADDR_W = 64;
  localparam int MEM_REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [MEM_DATA_W-1:0] data_from_mem;
    logic [MEM_DATA_W-1:0] alu_result;
    logic [MEM_REG_W-1:0]  rd;
  } mem_wb_t;

  // Byte transfers are never checked; doublewords must sit on an 8-byte boundary.
  function automatic logic dw_misaligned(input logic byte_xfer, input logic [2:0] addr_lo);
    return !byte_xfer && (addr_lo != 3'b000);
  endfunction

endpackage

// File: rtl/load_data_extend.sv
// Selects the loaded value: the low byte zero-extended for LDURB, the full
// doubleword otherwise. Purely combinational.
module load_data_extend #(
  parameter int DATA_W = 64
) (
  input  logic              byte_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = byte_i ? {{(DATA_W-8){1'b0}}, rdata_i[7:0]} : rdata_i;

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: issues loads/stores on a valid/ready data-memory port, stalls the
// front of the pipeline while an access is outstanding, and owns the MEM/WB register.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int REG_W  = MEM_REG_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite_MEMRegister,
  input  logic              MemToReg_MEMRegister,
  input  logic              MemRead_MEMRegister,
  input  logic              MemWrite_MEMRegister,
  input  logic              ByteXfer_MEMRegister,
  input  logic [DATA_W-1:0] ALUResult_MEMRegister,
  input  logic [DATA_W-1:0] StoreData_MEMRegister,
  input  logic [REG_W-1:0]  Rd_MEMRegister,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic              dmem_byte,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              stall_mem,
  output logic              misalign_fault,
  output logic              RegWrite_WBRegister,
  output logic              MemToReg_WBRegister,
  output logic [DATA_W-1:0] dataFromMem_WBRegister,
  output logic [DATA_W-1:0] ALUResult_WBRegister,
  output logic [REG_W-1:0]  Rd_WBRegister
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              byte_q;
  logic              capture;
  logic              fault_q, fault_d;
  mem_wb_t           wb_q, wb_d, wb_pass;
  logic              memop;
  logic              misaligned;
  logic [DATA_W-1:0] load_data;

  assign memop      = MemRead_MEMRegister | MemWrite_MEMRegister;
  assign misaligned = memop && dw_misaligned(ByteXfer_MEMRegister, ALUResult_MEMRegister[2:0]);

  load_data_extend #(
    .DATA_W (DATA_W)
  ) u_load_data_extend (
    .byte_i  (byte_q),
    .rdata_i (dmem_rsp_rdata),
    .data_o  (load_data)
  );

  // Upstream holds EX/MEM stable while stalled, so the live inputs are still
  // the instruction being retired when the access completes.
  always_comb begin
    wb_pass               = '0;
    wb_pass.reg_write     = RegWrite_MEMRegister;
    wb_pass.mem_to_reg    = MemToReg_MEMRegister;
    wb_pass.alu_result    = ALUResult_MEMRegister;
    wb_pass.rd            = Rd_MEMRegister;
  end

  always_comb begin
    state_d   = state_q;
    stall_mem = 1'b0;
    capture   = 1'b0;
    fault_d   = 1'b0;
    wb_d      = '0;
    case (state_q)
      IDLE: begin
        if (!memop) begin
          wb_d = wb_pass;
        end else if (misaligned) begin
          fault_d = 1'b1;
        end else begin
          capture   = 1'b1;
          stall_mem = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (!dmem_req_ready) begin
          stall_mem = 1'b1;
        end else if (we_q) begin
          state_d = IDLE;
          wb_d    = wb_pass;
        end else begin
          state_d   = WAIT;
          stall_mem = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          state_d            = IDLE;
          wb_d               = wb_pass;
          wb_d.data_from_mem = load_data;
        end else begin
          stall_mem = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      fault_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wb_q    <= wb_d;
      if (capture) begin
        addr_q  <= ALUResult_MEMRegister[ADDR_W-1:0];
        wdata_q <= StoreData_MEMRegister;
        we_q    <= MemWrite_MEMRegister;
        byte_q  <= ByteXfer_MEMRegister;
      end
    end
  end

  assign dmem_req_valid         = (state_q == REQ);
  assign dmem_we                = we_q;
  assign dmem_byte              = byte_q;
  assign dmem_addr              = addr_q;
  assign dmem_wdata             = wdata_q;
  assign misalign_fault         = fault_q;
  assign RegWrite_WBRegister    = wb_q.reg_write;
  assign MemToReg_WBRegister    = wb_q.mem_to_reg;
  assign dataFromMem_WBRegister = wb_q.data_from_mem;
  assign ALUResult_WBRegister   = wb_q.alu_result;
  assign Rd_WBRegister          = wb_q.rd;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases, then randomized instruction
// streams against a byte-addressed memory model with a WB scoreboard.
module tb_memory_access_stage;

  logic        clk;
  logic        reset_n;
  logic        RegWrite_MEMRegister, MemToReg_MEMRegister, MemRead_MEMRegister;
  logic        MemWrite_MEMRegister, ByteXfer_MEMRegister;
  logic [63:0] ALUResult_MEMRegister, StoreData_MEMRegister;
  logic [4:0]  Rd_MEMRegister;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_byte;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        stall_mem, misalign_fault;
  logic        RegWrite_WBRegister, MemToReg_WBRegister;
  logic [63:0] dataFromMem_WBRegister, ALUResult_WBRegister;
  logic [4:0]  Rd_WBRegister;

  memory_access_stage dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .RegWrite_MEMRegister   (RegWrite_MEMRegister),
    .MemToReg_MEMRegister   (MemToReg_MEMRegister),
    .MemRead_MEMRegister    (MemRead_MEMRegister),
    .MemWrite_MEMRegister   (MemWrite_MEMRegister),
    .ByteXfer_MEMRegister   (ByteXfer_MEMRegister),
    .ALUResult_MEMRegister  (ALUResult_MEMRegister),
    .StoreData_MEMRegister  (StoreData_MEMRegister),
    .Rd_MEMRegister         (Rd_MEMRegister),
    .dmem_req_valid         (dmem_req_valid),
    .dmem_req_ready         (dmem_req_ready),
    .dmem_we                (dmem_we),
    .dmem_byte              (dmem_byte),
    .dmem_addr              (dmem_addr),
    .dmem_wdata             (dmem_wdata),
    .dmem_rsp_valid         (dmem_rsp_valid),
    .dmem_rsp_rdata         (dmem_rsp_rdata),
    .stall_mem              (stall_mem),
    .misalign_fault         (misalign_fault),
    .RegWrite_WBRegister    (RegWrite_WBRegister),
    .MemToReg_WBRegister    (MemToReg_WBRegister),
    .dataFromMem_WBRegister (dataFromMem_WBRegister),
    .ALUResult_WBRegister   (ALUResult_WBRegister),
    .Rd_WBRegister          (Rd_WBRegister)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          fault;
    logic        rw;
    logic        m2r;
    logic [63:0] dfm;
    logic [63:0] alu;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic        we;
    logic        bx;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  logic [7:0] ref_mem [logic [63:0]];
  logic [7:0] dev_mem [logic [63:0]];

  int ready_mode  = 0;
  int hold_low    = 0;
  int delay_force = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] ref_byte(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [7:0] dev_byte(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic bx);
    logic [63:0] v;
    v = '0;
    if (bx) v[7:0] = ref_byte(a);
    else for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_byte(a + 64'(i));
    return v;
  endfunction

  function automatic logic [63:0] dev_load(input logic [63:0] a, input logic bx);
    logic [63:0] v;
    v = '0;
    if (bx) v[7:0] = dev_byte(a);
    else for (int i = 0; i < 8; i++) v[8*i +: 8] = dev_byte(a + 64'(i));
    return v;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [63:0] d, input logic bx);
    if (bx) ref_mem[a] = d[7:0];
    else for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = d[8*i +: 8];
  endtask

  task automatic dev_store(input logic [63:0] a, input logic [63:0] d, input logic bx);
    if (bx) dev_mem[a] = d[7:0];
    else for (int i = 0; i < 8; i++) dev_mem[a + 64'(i)] = d[8*i +: 8];
  endtask

  task automatic idle_in();
    RegWrite_MEMRegister  = 1'b0;
    MemToReg_MEMRegister  = 1'b0;
    MemRead_MEMRegister   = 1'b0;
    MemWrite_MEMRegister  = 1'b0;
    ByteXfer_MEMRegister  = 1'b0;
    ALUResult_MEMRegister = '0;
    StoreData_MEMRegister = '0;
    Rd_MEMRegister        = '0;
  endtask

  // Data-memory device: random ready/response timing, request checking,
  // request stability while not accepted, and spurious rsp_valid when idle.
  initial begin
    bit          pend;
    bit          outstanding;
    int          rsp_wait;
    req_t        last;
    req_t        e;
    logic [63:0] rsp_data;
    logic [63:0] junk;
    pend = 0; outstanding = 0; rsp_wait = 0; rsp_data = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("req_hold_valid", 64'(dmem_req_valid), 64'd1);
          chk("req_hold_addr", dmem_addr, last.addr);
          chk("req_hold_we", 64'(dmem_we), 64'(last.we));
          chk("req_hold_byte", 64'(dmem_byte), 64'(last.bx));
          chk("req_hold_wdata", dmem_wdata, last.wdata);
        end
        if (dmem_req_valid && dmem_req_ready) begin
          pend = 0;
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got request addr %h expected none", dmem_addr);
          end else begin
            e = req_q.pop_front();
            chk("req_we", 64'(dmem_we), 64'(e.we));
            chk("req_byte", 64'(dmem_byte), 64'(e.bx));
            chk("req_addr", dmem_addr, e.addr);
            chk("req_wdata", e.bx ? {56'b0, dmem_wdata[7:0]} : dmem_wdata,
                             e.bx ? {56'b0, e.wdata[7:0]} : e.wdata);
          end
          if (dmem_we) begin
            dev_store(dmem_addr, dmem_wdata, dmem_byte);
          end else begin
            outstanding = 1;
            rsp_wait    = (delay_force >= 0) ? delay_force : int'($urandom_range(0, 2));
            rsp_data    = dev_load(dmem_addr, dmem_byte);
            if (dmem_byte) begin
              junk           = {$urandom, $urandom};
              rsp_data[63:8] = junk[55:0];
            end
          end
        end else if (dmem_req_valid) begin
          pend = 1;
          last = '{dmem_we, dmem_byte, dmem_addr, dmem_wdata};
        end else begin
          pend = 0;
        end
      end
      @(posedge clk);
      #2;
      if (hold_low > 0) begin
        dmem_req_ready = 1'b0;
        hold_low--;
      end else begin
        dmem_req_ready = (ready_mode == 1) ? 1'b1 : 1'($urandom % 2);
      end
      if (outstanding) begin
        if (rsp_wait == 0) begin
          dmem_rsp_valid = 1'b1;
          dmem_rsp_rdata = rsp_data;
          outstanding    = 0;
        end else begin
          dmem_rsp_valid = 1'b0;
          rsp_wait--;
        end
      end else begin
        dmem_rsp_valid = ($urandom % 4 == 0);
        dmem_rsp_rdata = {$urandom, $urandom};
      end
    end
  end

  // WB monitor: anything other than an all-zero bubble is a retirement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (RegWrite_WBRegister || MemToReg_WBRegister || misalign_fault ||
                      dataFromMem_WBRegister != 0 || ALUResult_WBRegister != 0 || Rd_WBRegister != 0)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got rw=%b alu=%h fault=%b expected no retirement",
                   RegWrite_WBRegister, ALUResult_WBRegister, misalign_fault);
        end else begin
          e = exp_q.pop_front();
          chk("wb_fault", 64'(misalign_fault), 64'(e.fault));
          chk("wb_regwrite", 64'(RegWrite_WBRegister), 64'(e.rw));
          chk("wb_memtoreg", 64'(MemToReg_WBRegister), 64'(e.m2r));
          chk("wb_datafrommem", dataFromMem_WBRegister, e.dfm);
          chk("wb_aluresult", ALUResult_WBRegister, e.alu);
          chk("wb_rd", 64'(Rd_WBRegister), 64'(e.rd));
        end
      end
    end
  end

  // kind: 0 ADD, 1 LDUR, 2 LDURB, 3 STUR, 4 STURB. Called #1 after a posedge.
  task automatic issue(input int kind, input logic [63:0] addr, input logic [63:0] sd,
                       input logic [4:0] rd, output int n);
    exp_t e;
    bit   mem, bx, ld, st, mis;
    mem = (kind != 0);
    bx  = (kind == 2) || (kind == 4);
    ld  = (kind == 1) || (kind == 2);
    st  = (kind == 3) || (kind == 4);
    mis = mem && !bx && (addr[2:0] != 3'b000);
    RegWrite_MEMRegister  = !st;
    MemToReg_MEMRegister  = ld;
    MemRead_MEMRegister   = ld;
    MemWrite_MEMRegister  = st;
    ByteXfer_MEMRegister  = bx;
    ALUResult_MEMRegister = addr;
    StoreData_MEMRegister = sd;
    Rd_MEMRegister        = rd;
    if (mis) e = '{1, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0};
    else if (ld) e = '{0, 1'b1, 1'b1, ref_load(addr, bx), addr, rd};
    else if (st) begin
      e = '{0, 1'b0, 1'b0, 64'd0, addr, rd};
      ref_store(addr, sd, bx);
    end else e = '{0, 1'b1, 1'b0, 64'd0, addr, rd};
    exp_q.push_back(e);
    if (mem && !mis) req_q.push_back('{st, bx, addr, sd});
    n = 0;
    @(negedge clk);
    while (stall_mem !== 1'b0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL stall_timeout: got stall_mem still high after %0d cycles expected release", n);
    end
    if (!mem || mis) chk("stall_none", 64'(n), 64'd0);
    else if (st)     chk("stall_store_min", 64'(n >= 1), 64'd1);
    else             chk("stall_load_min", 64'(n >= 2), 64'd1);
    @(posedge clk);
    #1;
    if (mis) chk("fault_pulse", 64'(misalign_fault), 64'd1);
    else begin
      chk("wb_latency_alu", ALUResult_WBRegister, addr);
      chk("wb_latency_rd", 64'(Rd_WBRegister), 64'(rd));
    end
  endtask

  initial begin
    int          n;
    int          kind;
    logic [63:0] a;
    reset_n = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_regwrite", 64'(RegWrite_WBRegister), 64'd0);
    chk("rst_memtoreg", 64'(MemToReg_WBRegister), 64'd0);
    chk("rst_datafrommem", dataFromMem_WBRegister, 64'd0);
    chk("rst_aluresult", ALUResult_WBRegister, 64'd0);
    chk("rst_rd", 64'(Rd_WBRegister), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_fault", 64'(misalign_fault), 64'd0);
    chk("rst_stall", 64'(stall_mem), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 64'h1234, 64'd0, 5'd5, n);

    ready_mode = 1; delay_force = 0;
    issue(3, 64'h40, 64'hDEADBEEF_CAFEF00D, 5'd1, n);
    chk("t2_store_stall", 64'(n), 64'd1);
    issue(1, 64'h40, 64'd0, 5'd2, n);
    chk("t2_load_stall", 64'(n), 64'd2);

    hold_low = 5;
    issue(4, 64'h43, 64'hAB, 5'd3, n);
    chk("t3_store_stall", 64'(n), 64'd5);

    issue(1, 64'h44, 64'd0, 5'd4, n);

    issue(3, 64'h150, 64'hFFFF_FFFF_FFFF_FF80, 5'd6, n);
    issue(2, 64'h150, 64'd0, 5'd8, n);

    ready_mode = 0; delay_force = -1;
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 4));
      if (kind == 0) a = {$urandom, $urandom} | 64'd1;
      else begin
        a = 64'h100 + 64'($urandom_range(0, 63));
        if ((kind == 1 || kind == 3) && ($urandom % 6 != 0)) a[2:0] = 3'b000;
      end
      issue(kind, a, {$urandom, $urandom}, 5'($urandom), n);
    end

    idle_in();
    repeat (3) @(posedge clk);
    #1;
    ready_mode = 1; delay_force = 5;
    RegWrite_MEMRegister  = 1'b1;
    MemToReg_MEMRegister  = 1'b1;
    MemRead_MEMRegister   = 1'b1;
    ALUResult_MEMRegister = 64'h80;
    Rd_MEMRegister        = 5'd7;
    req_q.push_back('{1'b0, 1'b0, 64'h80, 64'd0});
    repeat (3) @(negedge clk);
    chk("t6_stall_in_wait", 64'(stall_mem), 64'd1);
    #1;
    reset_n = 1'b0;
    idle_in();
    #1;
    chk("t6_rst_regwrite", 64'(RegWrite_WBRegister), 64'd0);
    chk("t6_rst_memtoreg", 64'(MemToReg_WBRegister), 64'd0);
    chk("t6_rst_datafrommem", dataFromMem_WBRegister, 64'd0);
    chk("t6_rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("t6_rst_fault", 64'(misalign_fault), 64'd0);
    chk("t6_rst_stall", 64'(stall_mem), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t6_post_rsp_regwrite", 64'(RegWrite_WBRegister), 64'd0);
    chk("t6_post_rsp_data", dataFromMem_WBRegister, 64'd0);
    chk("t6_post_rsp_stall", 64'(stall_mem), 64'd0);
    ready_mode = 0; delay_force = -1;
    @(posedge clk);
    #1;
    issue(0, 64'h5555, 64'd0, 5'd9, n);

    idle_in();
    repeat (5) @(posedge clk);
    #1;
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
